trap_ctrl: RTL

//  Trap sequencer driving the CSR exception-write port and the fetch redirect. Takes exception/mret/interrupt

---
 rtl/trap_pkg.sv | 28 ++
 rtl/trap_target_calc.sv | 28 ++
 rtl/trap_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, event kinds
// and the mcause codes the sequencer produces or recognises.
package trap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StWrcsr,
    StRedirect
  } trap_state_e;

  typedef enum logic [1:0] {
    KindTrap,
    KindTrapIrq,
    KindRet
  } trap_kind_e;

  localparam logic [3:0]  CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0]  CAUSE_BREAK    = 4'd3;
  localparam logic [3:0]  CAUSE_ECALL_M  = 4'd11;
  localparam logic [3:0]  CAUSE_MTI      = 4'd7;
  localparam int unsigned MCAUSE_IRQ_BIT = 63;

  function automatic logic [63:0] align4(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/trap_target_calc.sv
// Combinational fetch-redirect target: mepc for mret, mtvec base for traps,
// plus the vectored offset for interrupts when mtvec selects vectored mode.
module trap_target_calc
  import trap_pkg::*;
#(
  parameter bit VECTORED_EN = 1'b1
) (
  input  trap_kind_e  kind_i,
  input  logic [3:0]  cause_i,
  input  logic [63:0] mtvec_i,
  input  logic [63:0] mepc_i,
  output logic [63:0] target_o
);

  always_comb begin
    target_o = align4(mtvec_i);
    unique case (kind_i)
      KindRet: target_o = align4(mepc_i);
      KindTrapIrq: begin
        if (VECTORED_EN && (mtvec_i[1:0] == 2'b01)) begin
          target_o = align4(mtvec_i) + {58'd0, cause_i, 2'b00};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: captures exception/mret/interrupt events from commit, flushes the
// pipeline, writes mepc/mcause to the CSR file and redirects fetch.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter bit          VECTORED_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [63:0] exc_pc_i,
  input  logic        mret_valid_i,
  input  logic        irq_pending_i,
  input  logic        commit_valid_i,
  input  logic [63:0] commit_pc_next_i,
  input  logic [63:0] mtvec_val_i,
  input  logic [63:0] mepc_val_i,
  output logic        excep_wen_o,
  output logic [63:0] mepc_overri_o,
  output logic [63:0] mcause_overri_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic [31:0] trap_count_o
);

  localparam logic [3:0]  FlushLoad   = 4'(FLUSH_CYCLES - 1);
  localparam logic [63:0] McauseIrqMt = (64'd1 << MCAUSE_IRQ_BIT) | {60'd0, CAUSE_MTI};

  trap_state_e state_q;
  trap_kind_e  kind_q;
  logic [3:0]  flush_cnt_q;
  logic [63:0] mepc_lat_q, mcause_lat_q;
  logic        excep_wen_q, flush_q, stall_q, redirect_valid_q;
  logic [63:0] mepc_overri_q, mcause_overri_q, redirect_pc_q;
  logic [31:0] trap_count_q;
  logic [63:0] target;

  trap_target_calc #(
    .VECTORED_EN(VECTORED_EN)
  ) u_target (
    .kind_i  (kind_q),
    .cause_i (mcause_lat_q[3:0]),
    .mtvec_i (mtvec_val_i),
    .mepc_i  (mepc_val_i),
    .target_o(target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      kind_q           <= KindTrap;
      flush_cnt_q      <= '0;
      mepc_lat_q       <= '0;
      mcause_lat_q     <= '0;
      excep_wen_q      <= 1'b0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      mepc_overri_q    <= '0;
      mcause_overri_q  <= '0;
      redirect_pc_q    <= '0;
      trap_count_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (exc_valid_i || mret_valid_i || (irq_pending_i && commit_valid_i)) begin
            state_q     <= StFlush;
            flush_q     <= 1'b1;
            stall_q     <= 1'b1;
            flush_cnt_q <= FlushLoad;
          end
          if (exc_valid_i) begin
            kind_q       <= KindTrap;
            mepc_lat_q   <= exc_pc_i;
            mcause_lat_q <= {60'd0, exc_cause_i};
          end else if (mret_valid_i) begin
            kind_q <= KindRet;
          end else if (irq_pending_i && commit_valid_i) begin
            kind_q       <= KindTrapIrq;
            mepc_lat_q   <= commit_pc_next_i;
            mcause_lat_q <= McauseIrqMt;
          end
        end
        StFlush: begin
          if (flush_cnt_q == 4'd0) begin
            flush_q <= 1'b0;
            if (kind_q == KindRet) begin
              state_q          <= StRedirect;
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= target;
            end else begin
              state_q         <= StWrcsr;
              excep_wen_q     <= 1'b1;
              mepc_overri_q   <= mepc_lat_q;
              mcause_overri_q <= mcause_lat_q;
            end
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        StWrcsr: begin
          // Target is sampled only after the CSR write strobe has been issued.
          state_q          <= StRedirect;
          excep_wen_q      <= 1'b0;
          mepc_overri_q    <= '0;
          mcause_overri_q  <= '0;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= target;
        end
        StRedirect: begin
          if (redirect_ready_i) begin
            state_q          <= StIdle;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            if (kind_q != KindRet) trap_count_q <= trap_count_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign excep_wen_o      = excep_wen_q;
  assign mepc_overri_o    = mepc_overri_q;
  assign mcause_overri_o  = mcause_overri_q;
  assign flush_o          = flush_q;
  assign stall_o          = stall_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign trap_count_o     = trap_count_q;

endmodule
